// File: rtl/counter_pkg.sv
// counter_pkg: shared width default and the all-ones maximum helper for the counter.
package counter_pkg;

    localparam int COUNTER_DEFAULT_WIDTH = 8;

    function automatic logic [31:0] max_val(input int width);
        return (width >= 32) ? 32'hFFFF_FFFF : (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/counter_tc.sv
// counter_tc: terminal-count detection plus next-value and wrap-pulse logic.
// COUNTER_SATURATE_EN holds the count at the maximum and pulses wrap only once.
module counter_tc
    import counter_pkg::*;
#(
    parameter int width_p = COUNTER_DEFAULT_WIDTH
) (
    input  logic [width_p-1:0] count,
    input  logic               en,
`ifdef COUNTER_SATURATE_EN
    input  logic               done,
`endif
    output logic               max,
    output logic [width_p-1:0] next,
    output logic               wrap
);

    localparam logic [width_p-1:0] max_c = width_p'(max_val(width_p));

    always_comb begin
        max = count == max_c;
`ifdef COUNTER_SATURATE_EN
        next = (en && !max) ? count + width_p'(1) : count;
        wrap = en && max && !done;
`else
        next = en ? count + width_p'(1) : count;
        wrap = en && max;
`endif
    end

endmodule

// File: rtl/counter.sv
// counter: enabled up-counter with registered wrap pulse and combinational max flag.
// COUNTER_SATURATE_EN selects saturation at the maximum instead of wrapping to 0.
module counter
    import counter_pkg::*;
#(
    parameter int width_p = COUNTER_DEFAULT_WIDTH
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_o,
    output logic               wrap_o,
    output logic               max_o
);

    logic [width_p-1:0] next;
    logic               wrap;
`ifdef COUNTER_SATURATE_EN
    logic               done;
`endif

    counter_tc #(.width_p(width_p)) u_tc (
        .count (count_o),
        .en    (en_i),
`ifdef COUNTER_SATURATE_EN
        .done  (done),
`endif
        .max   (max_o),
        .next  (next),
        .wrap  (wrap)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_o <= '0;
            wrap_o  <= 1'b0;
        end else begin
            count_o <= next;
            wrap_o  <= wrap;
        end
    end

`ifdef COUNTER_SATURATE_EN
    // Remembers that the saturation pulse has fired; only reset re-arms it.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            done <= 1'b0;
        else if (wrap)
            done <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_counter.sv
// tb_counter: directed and randomized checks of counter against a modular-arithmetic model.
module tb_counter;

    localparam int MAX = 255;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       en_i = 1'b0;
    logic [7:0] count_o;
    logic       wrap_o;
    logic       max_o;

    int checks = 0;
    int errors = 0;
    int m_count = 0;
    int m_wrap = 0;
    bit m_seen = 1'b0;
    int pulses = 0;

    counter dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (en_i),
        .count_o (count_o),
        .wrap_o  (wrap_o),
        .max_o   (max_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step(input logic r, input logic e);
        reset_i = r;
        en_i = e;
        @(posedge clk_i);
        if (r) begin
            m_count = 0;
            m_wrap = 0;
            m_seen = 1'b0;
        end else if (e) begin
`ifdef COUNTER_SATURATE_EN
            m_wrap = (m_count == MAX && !m_seen) ? 1 : 0;
            if (m_count == MAX) m_seen = 1'b1;
            m_count = (m_count + 1 > MAX) ? MAX : m_count + 1;
`else
            m_wrap = (m_count == MAX) ? 1 : 0;
            m_count = (m_count + 1) % (MAX + 1);
`endif
        end else begin
            m_wrap = 0;
        end
        #1;
        if (wrap_o === 1'b1) pulses++;
        chk("count", 32'(count_o), 32'(m_count));
        chk("wrap", 32'(wrap_o), 32'(m_wrap));
        chk("max", 32'(max_o), 32'(m_count == MAX));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("reset_count", 32'(count_o), 32'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        chk("count_20", 32'(count_o), 32'd20);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        chk("hold_20", 32'(count_o), 32'd20);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("reset_priority", 32'(count_o), 32'd0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("post_reset_2", 32'(count_o), 32'd2);
        while (m_count != MAX) step(1'b0, 1'b1);
        chk("at_max", 32'(max_o), 32'd1);
        pulses = 0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("wrap_once", 32'(pulses), 32'd1);
        step(1'b1, 1'b0);
        pulses = 0;
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1);
        chk("pulses_300", 32'(pulses), 32'd1);
`ifdef COUNTER_SATURATE_EN
        chk("count_300", 32'(count_o), 32'd255);
`else
        chk("count_300", 32'(count_o), 32'd44);
`endif
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
